// File: rtl/ex_stage_pkg.sv
// ============================================================================
// ex_stage_pkg : shared datapath config, ALU opcodes and operand/branch selects
// Revision     : 1.0
// ============================================================================
`default_nettype none

package ex_stage_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int REG_ADDR_WIDTH = 5;

   localparam logic [5:0] OP_ALU_ADD  = 6'd0;
   localparam logic [5:0] OP_ALU_SUB  = 6'd1;
   localparam logic [5:0] OP_ALU_SLL  = 6'd2;
   localparam logic [5:0] OP_ALU_SLT  = 6'd3;
   localparam logic [5:0] OP_ALU_SLTU = 6'd4;
   localparam logic [5:0] OP_ALU_XOR  = 6'd5;
   localparam logic [5:0] OP_ALU_SRL  = 6'd6;
   localparam logic [5:0] OP_ALU_SRA  = 6'd7;
   localparam logic [5:0] OP_ALU_OR   = 6'd8;
   localparam logic [5:0] OP_ALU_AND  = 6'd9;

   localparam logic [1:0] ASEL_RS1  = 2'd0;
   localparam logic [1:0] ASEL_PC   = 2'd1;
   localparam logic [1:0] ASEL_ZERO = 2'd2;

   localparam logic BSEL_RS2 = 1'b0;
   localparam logic BSEL_IMM = 1'b1;

   localparam logic [3:0] BR_NONE = 4'd0;
   localparam logic [3:0] BR_BEQ  = 4'd1;
   localparam logic [3:0] BR_BNE  = 4'd2;
   localparam logic [3:0] BR_BLT  = 4'd3;
   localparam logic [3:0] BR_BGE  = 4'd4;
   localparam logic [3:0] BR_BLTU = 4'd5;
   localparam logic [3:0] BR_BGEU = 4'd6;
   localparam logic [3:0] BR_JAL  = 4'd7;
   localparam logic [3:0] BR_JALR = 4'd8;

endpackage

`default_nettype wire

// File: rtl/ex_stage_alu.sv
// ============================================================================
// alu : RV32I integer ALU, purely combinational
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu #(
   parameter int WIDTH = ex_stage_pkg::DATA_WIDTH
) (
   input  logic [5:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] c_o
);
   import ex_stage_pkg::*;

   logic [4:0] shamt;
   assign shamt = b_i[4:0];

   always_comb begin
      c_o = '0;
      case (op_i)
         OP_ALU_ADD:  c_o = a_i + b_i;
         OP_ALU_SUB:  c_o = a_i - b_i;
         OP_ALU_SLL:  c_o = a_i << shamt;
         OP_ALU_SLT:  c_o = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
         OP_ALU_SLTU: c_o = {{(WIDTH-1){1'b0}}, a_i < b_i};
         OP_ALU_XOR:  c_o = a_i ^ b_i;
         OP_ALU_SRL:  c_o = a_i >> shamt;
         OP_ALU_SRA:  c_o = $signed(a_i) >>> shamt;
         OP_ALU_OR:   c_o = a_i | b_i;
         OP_ALU_AND:  c_o = a_i & b_i;
         default:     c_o = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// ex_stage : RV32I execute stage with branch resolution and one output register
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_stage #(
   parameter int DATA_WIDTH     = ex_stage_pkg::DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = ex_stage_pkg::REG_ADDR_WIDTH
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   input  logic [5:0]                alu_op_i,
   input  logic [1:0]                a_sel_i,
   input  logic                      b_sel_i,
   input  logic [3:0]                br_type_i,
   input  logic [DATA_WIDTH-1:0]     rs1_data_i,
   input  logic [DATA_WIDTH-1:0]     rs2_data_i,
   input  logic [DATA_WIDTH-1:0]     imm_i,
   input  logic [DATA_WIDTH-1:0]     pc_i,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
   input  logic                      rd_we_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [DATA_WIDTH-1:0]     result_o,
   output logic [DATA_WIDTH-1:0]     store_data_o,
   output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
   output logic                      rd_we_o,
   output logic [DATA_WIDTH-1:0]     pc_o,
   output logic                      redirect_o,
   output logic [DATA_WIDTH-1:0]     redirect_pc_o
);
   import ex_stage_pkg::*;

   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;
   logic [DATA_WIDTH-1:0] alu_c;
   logic [DATA_WIDTH-1:0] link_addr;
   logic                  is_branch;
   logic                  is_jump;
   logic                  taken;
   logic                  accept;

   always_comb begin
      op_a = rs1_data_i;
      case (a_sel_i)
         ASEL_PC:   op_a = pc_i;
         ASEL_ZERO: op_a = '0;
         default:   op_a = rs1_data_i;
      endcase
   end

   assign op_b = (b_sel_i == BSEL_IMM) ? imm_i : rs2_data_i;

   alu #(.WIDTH(DATA_WIDTH)) u_alu (
      .op_i (alu_op_i),
      .a_i  (op_a),
      .b_i  (op_b),
      .c_o  (alu_c)
   );

   assign link_addr = pc_i + {{(DATA_WIDTH-3){1'b0}}, 3'b100};
   assign is_jump   = (br_type_i == BR_JAL) || (br_type_i == BR_JALR);
   assign is_branch = (br_type_i >= BR_BEQ) && (br_type_i <= BR_BGEU);

   // Comparator always looks at the raw register values, never the ALU operands.
   always_comb begin
      taken = 1'b0;
      case (br_type_i)
         BR_BEQ:  taken = (rs1_data_i == rs2_data_i);
         BR_BNE:  taken = (rs1_data_i != rs2_data_i);
         BR_BLT:  taken = ($signed(rs1_data_i) <  $signed(rs2_data_i));
         BR_BGE:  taken = ($signed(rs1_data_i) >= $signed(rs2_data_i));
         BR_BLTU: taken = (rs1_data_i <  rs2_data_i);
         BR_BGEU: taken = (rs1_data_i >= rs2_data_i);
         BR_JAL,
         BR_JALR: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   assign ready_o = !valid_o || ready_i;
   assign accept  = valid_i && ready_o && !flush_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o       <= 1'b0;
         redirect_o    <= 1'b0;
         result_o      <= '0;
         store_data_o  <= '0;
         rd_addr_o     <= '0;
         rd_we_o       <= 1'b0;
         pc_o          <= '0;
         redirect_pc_o <= '0;
      end else begin
         redirect_o <= 1'b0;
         if (flush_i) begin
            valid_o <= 1'b0;
         end else if (accept) begin
            valid_o       <= 1'b1;
            redirect_o    <= taken;
            result_o      <= is_jump ? link_addr : alu_c;
            store_data_o  <= rs2_data_i;
            rd_addr_o     <= rd_addr_i;
            rd_we_o       <= rd_we_i && (rd_addr_i != '0) && !is_branch;
            pc_o          <= pc_i;
            redirect_pc_o <= {alu_c[DATA_WIDTH-1:1], 1'b0};
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// tb_ex_stage : scoreboard bench for the execute stage
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ex_stage;
   import ex_stage_pkg::*;

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] store;
      logic [31:0] pc;
      logic [31:0] rpc;
      logic [4:0]  rd;
      logic        we;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b1;
   logic        flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
   logic [5:0]  alu_op_i = '0;
   logic [1:0]  a_sel_i = '0;
   logic        b_sel_i = 1'b0;
   logic [3:0]  br_type_i = '0;
   logic [31:0] rs1_data_i = '0, rs2_data_i = '0, imm_i = '0, pc_i = '0;
   logic [4:0]  rd_addr_i = '0;
   logic        rd_we_i = 1'b0;
   logic        ready_o, valid_o, rd_we_o, redirect_o;
   logic [31:0] result_o, store_data_o, pc_o, redirect_pc_o;
   logic [4:0]  rd_addr_o;

   int   n_checks = 0;
   int   n_pass = 0;
   exp_t sb[$];
   logic m_valid = 1'b0;
   logic m_redir = 1'b0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
      .ready_o(ready_o), .alu_op_i(alu_op_i), .a_sel_i(a_sel_i), .b_sel_i(b_sel_i),
      .br_type_i(br_type_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .imm_i(imm_i), .pc_i(pc_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
      .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
      .store_data_o(store_data_o), .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o),
      .pc_o(pc_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         OP_ALU_ADD:  return a + b;
         OP_ALU_SUB:  return a - b;
         OP_ALU_SLL:  return a << b[4:0];
         OP_ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
         OP_ALU_XOR:  return a ^ b;
         OP_ALU_SRL:  return a >> b[4:0];
         OP_ALU_SRA:  return $signed(a) >>> b[4:0];
         OP_ALU_OR:   return a | b;
         OP_ALU_AND:  return a & b;
         default:     return 32'd0;
      endcase
   endfunction

   function automatic logic ref_taken();
      case (br_type_i)
         BR_BEQ:  return rs1_data_i == rs2_data_i;
         BR_BNE:  return rs1_data_i != rs2_data_i;
         BR_BLT:  return $signed(rs1_data_i) < $signed(rs2_data_i);
         BR_BGE:  return $signed(rs1_data_i) >= $signed(rs2_data_i);
         BR_BLTU: return rs1_data_i < rs2_data_i;
         BR_BGEU: return rs1_data_i >= rs2_data_i;
         BR_JAL, BR_JALR: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t predict();
      exp_t        e;
      logic [31:0] a, b, c;
      a = (a_sel_i == ASEL_PC) ? pc_i : (a_sel_i == ASEL_ZERO) ? 32'd0 : rs1_data_i;
      b = b_sel_i ? imm_i : rs2_data_i;
      c = ref_alu(alu_op_i, a, b);
      e.result = (br_type_i == BR_JAL || br_type_i == BR_JALR) ? pc_i + 32'd4 : c;
      e.store  = rs2_data_i;
      e.pc     = pc_i;
      e.rpc    = c & 32'hFFFF_FFFE;
      e.rd     = rd_addr_i;
      e.we     = rd_we_i && (rd_addr_i != 5'd0) && !(br_type_i >= BR_BEQ && br_type_i <= BR_BGEU);
      return e;
   endfunction

   // One clock: inputs already driven after the negedge; check, then advance the model.
   task automatic cyc();
      exp_t e;
      logic exp_ready, acc, con, tk;
      #1;
      exp_ready = !m_valid || ready_i;
      check("ready_o", ready_o, exp_ready);
      check("valid_o", valid_o, m_valid);
      check("redirect_o", redirect_o, m_redir);
      if (m_valid && sb.size() > 0) begin
         e = sb[0];
         check("result_o", result_o, e.result);
         check("store_data_o", store_data_o, e.store);
         check("pc_o", pc_o, e.pc);
         check("redirect_pc_o", redirect_pc_o, e.rpc);
         check("rd_addr_o", rd_addr_o, e.rd);
         check("rd_we_o", rd_we_o, e.we);
      end
      acc = valid_i && exp_ready && !flush_i;
      con = m_valid && ready_i;
      e   = predict();
      tk  = ref_taken();
      @(posedge clk);
      if (m_valid && (con || flush_i) && sb.size() > 0) void'(sb.pop_front());
      m_redir = 1'b0;
      if (flush_i) m_valid = 1'b0;
      else if (acc) begin
         sb.push_back(e);
         m_valid = 1'b1;
         m_redir = tk;
      end else if (con) m_valid = 1'b0;
   endtask

   task automatic set_instr(input logic [5:0] op, input logic [1:0] asel, input logic bsel,
                            input logic [3:0] br, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] im, input logic [31:0] pc, input logic [4:0] rd,
                            input logic we);
      alu_op_i = op; a_sel_i = asel; b_sel_i = bsel; br_type_i = br;
      rs1_data_i = r1; rs2_data_i = r2; imm_i = im; pc_i = pc;
      rd_addr_i = rd; rd_we_i = we;
   endtask

   task automatic issue(input logic [5:0] op, input logic [1:0] asel, input logic bsel,
                        input logic [3:0] br, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] im, input logic [31:0] pc, input logic [4:0] rd,
                        input logic we);
      @(negedge clk);
      set_instr(op, asel, bsel, br, r1, r2, im, pc, rd, we);
      valid_i = 1'b1;
      cyc();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         valid_i = 1'b0;
         flush_i = 1'b0;
         cyc();
      end
   endtask

   initial begin
      #1 rst_ni = 1'b0;
      #10;
      check("rst valid_o", valid_o, 0);
      check("rst redirect_o", redirect_o, 0);
      check("rst result_o", result_o, 0);
      check("rst store_data_o", store_data_o, 0);
      check("rst pc_o", pc_o, 0);
      check("rst redirect_pc_o", redirect_pc_o, 0);
      check("rst rd_addr_o", rd_addr_o, 0);
      check("rst rd_we_o", rd_we_o, 0);
      @(negedge clk);
      rst_ni  = 1'b1;
      ready_i = 1'b1;

      // Directed cases
      issue(OP_ALU_ADD, ASEL_RS1, BSEL_RS2, BR_NONE, 32'd5, 32'd7, 32'd0, 32'h40, 5'd3, 1'b1);
      idle(1);
      issue(OP_ALU_ADD, ASEL_PC, BSEL_IMM, BR_BLT, 32'hFFFF_FFF0, 32'h10, 32'h20, 32'h100, 5'd4, 1'b1);
      idle(2);
      issue(OP_ALU_ADD, ASEL_PC, BSEL_IMM, BR_BLTU, 32'hFFFF_FFF0, 32'h10, 32'h20, 32'h100, 5'd4, 1'b1);
      idle(1);
      issue(OP_ALU_ADD, ASEL_RS1, BSEL_IMM, BR_JALR, 32'h1003, 32'h0, 32'h4, 32'h200, 5'd1, 1'b1);
      idle(2);
      issue(OP_ALU_ADD, ASEL_ZERO, BSEL_IMM, BR_NONE, 32'hDEAD, 32'h0, 32'h1234_5000, 32'h300, 5'd6, 1'b1);
      issue(OP_ALU_ADD, ASEL_PC, BSEL_IMM, BR_NONE, 32'h0, 32'h0, 32'hFFFF_F000, 32'h304, 5'd7, 1'b1);
      issue(OP_ALU_SRA, ASEL_RS1, BSEL_RS2, BR_NONE, 32'h8000_0000, 32'h24, 32'h0, 32'h308, 5'd8, 1'b1);
      issue(OP_ALU_ADD, ASEL_PC, BSEL_IMM, BR_BEQ, 32'h55, 32'h55, 32'hFFFF_FFF8, 32'h30C, 5'd9, 1'b1);
      issue(OP_ALU_ADD, ASEL_PC, BSEL_IMM, BR_JAL, 32'h0, 32'h0, 32'h11, 32'hFFFF_FFFC, 5'd0, 1'b1);
      idle(2);

      // Backpressure then simultaneous consume + accept
      issue(OP_ALU_XOR, ASEL_RS1, BSEL_RS2, BR_NONE, 32'hF0F0, 32'h0FF0, 32'h0, 32'h400, 5'd10, 1'b1);
      @(negedge clk);
      ready_i = 1'b0;
      set_instr(OP_ALU_SUB, ASEL_RS1, BSEL_RS2, BR_NONE, 32'd3, 32'd5, 32'h0, 32'h404, 5'd11, 1'b1);
      valid_i = 1'b1;
      cyc();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         cyc();
      end
      @(negedge clk);
      ready_i = 1'b1;
      cyc();
      idle(1);

      // Flush against a held entry, then flush during a redirect pulse
      @(negedge clk);
      ready_i = 1'b0;
      set_instr(OP_ALU_OR, ASEL_RS1, BSEL_RS2, BR_NONE, 32'h1, 32'h2, 32'h0, 32'h500, 5'd12, 1'b1);
      valid_i = 1'b1;
      cyc();
      @(negedge clk);
      flush_i = 1'b1;
      cyc();
      idle(1);
      ready_i = 1'b1;
      issue(OP_ALU_ADD, ASEL_PC, BSEL_IMM, BR_JAL, 32'h0, 32'h0, 32'h80, 32'h600, 5'd1, 1'b1);
      @(negedge clk);
      valid_i = 1'b0;
      flush_i = 1'b1;
      cyc();
      idle(2);

      // Asynchronous reset while an entry is held
      issue(OP_ALU_AND, ASEL_RS1, BSEL_RS2, BR_NONE, 32'hFF00, 32'h0FF0, 32'h0, 32'h700, 5'd13, 1'b1);
      @(negedge clk);
      valid_i = 1'b0;
      ready_i = 1'b0;
      #1 check("pre-reset valid_o", valid_o, 1);
      #1 rst_ni = 1'b0;
      #1;
      check("async valid_o", valid_o, 0);
      check("async result_o", result_o, 0);
      check("async rd_we_o", rd_we_o, 0);
      check("async pc_o", pc_o, 0);
      m_valid = 1'b0;
      m_redir = 1'b0;
      sb.delete();
      @(negedge clk);
      rst_ni  = 1'b1;
      ready_i = 1'b1;
      issue(OP_ALU_SLL, ASEL_RS1, BSEL_IMM, BR_NONE, 32'h3, 32'h0, 32'h21, 32'h800, 5'd14, 1'b1);
      idle(1);

      // Random traffic with random backpressure and occasional flush
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         set_instr(6'($urandom_range(0, 9)), 2'($urandom_range(0, 2)), 1'($urandom),
                   4'($urandom_range(0, 8)), $urandom, $urandom, $urandom, $urandom,
                   5'($urandom), 1'($urandom));
         valid_i = ($urandom_range(0, 3) != 0);
         ready_i = ($urandom_range(0, 3) != 0);
         flush_i = ($urandom_range(0, 15) == 0);
         cyc();
      end
      ready_i = 1'b1;
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RV32I pipeline, sitting between the decode stage and the memory/writeback stage.
- Selects ALU operands, drives the existing `alu` and resolves branches and jumps.
- Registers the result, destination and redirect information into a single-entry output register with a valid/ready handshake on both sides.
- Latency is 1 cycle; throughput is 1 instruction per cycle when downstream is ready.

Parameters:
- DATA_WIDTH, 32 (from pkg_config), datapath width.
- REG_ADDR_WIDTH, 5, register-file index width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  kill the held entry and any incoming instruction.
- valid_i  in  1  decode presents an instruction.
- ready_o  out  1  stage can accept this cycle.
- alu_op_i  in  6  OP_ALU_* code.
- a_sel_i  in  2  A operand: ASEL_RS1, ASEL_PC, ASEL_ZERO.
- b_sel_i  in  1  B operand: BSEL_RS2, BSEL_IMM.
- br_type_i  in  4  BR_NONE, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR.
- rs1_data_i  in  DATA_WIDTH  rs1 value.
- rs2_data_i  in  DATA_WIDTH  rs2 value.
- imm_i  in  DATA_WIDTH  sign-extended immediate.
- pc_i  in  DATA_WIDTH  instruction PC.
- rd_addr_i  in  REG_ADDR_WIDTH  destination register.
- rd_we_i  in  1  destination write enable.
- valid_o  out  1  output entry valid.
- ready_i  in  1  downstream accepts.
- result_o  out  DATA_WIDTH  ALU result, or link address for jumps.
- store_data_o  out  DATA_WIDTH  registered rs2 value.
- rd_addr_o  out  REG_ADDR_WIDTH  registered destination.
- rd_we_o  out  1  registered write enable, forced 0 when rd_addr is 0.
- pc_o  out  DATA_WIDTH  registered PC.
- redirect_o  out  1  one-cycle pulse: taken branch or jump.
- redirect_pc_o  out  DATA_WIDTH  redirect target.

Behaviour:
- Reset (async, rst_ni=0): valid_o=0, redirect_o=0; result_o, store_data_o, pc_o and redirect_pc_o = 0; rd_addr_o=0; rd_we_o=0.
- Handshake:
  - ready_o = !valid_o || ready_i, combinational; it does not depend on valid_i.
  - Accept on valid_i && ready_o && !flush_i.
  - An output is consumed when valid_o && ready_i.
  - On accept: register all outputs and set valid_o=1 on the next edge.
  - Consume without accept: valid_o=0.
  - Simultaneous consume and accept: new entry replaces old; valid_o stays 1, with no bubble.
  - No accept and no consume: all outputs hold, including while ready_i=0.
- Operands:
  - A = rs1 (ASEL_RS1), pc (ASEL_PC) or 0 (ASEL_ZERO; used for LUI).
  - B = rs2 (BSEL_RS2) or imm (BSEL_IMM).
  - AUIPC uses PC + IMM with ADD.
- result_o:
  - br_type JAL/JALR: pc_i+4, modulo 2^32.
  - Otherwise: ALU c_o.
- Branch compare is independent of the ALU and always operates on rs1_data_i/rs2_data_i:
  - BEQ/BNE: equality.
  - BLT/BGE: signed compare.
  - BLTU/BGEU: unsigned compare.
- Taken = JAL, JALR, or a branch whose condition holds. BR_NONE is never taken.
- Target = ALU c_o with bit 0 cleared. Decode sets PC+IMM for branches and JAL, and RS1+IMM for JALR. Bit 1 is not checked; misalignment exceptions are out of scope.
- Redirect:
  - redirect_o is asserted the cycle after accepting a taken instruction, for exactly one cycle, even if ready_i=0.
  - redirect_pc_o is registered with the entry and holds.
  - A not-taken branch produces no redirect.
- Branches have rd_we_o forced to 0. rd_we_o is also 0 whenever rd_addr is 0.
- flush_i:
  - Next edge: valid_o=0, redirect_o=0, and no accept that cycle regardless of valid_i.
  - Registered data fields may hold stale values.
  - A flush in the same cycle as a pending redirect pulse does not cancel the already-asserted pulse.
- Reset mid-operation clears the entry immediately (async). The first accept is possible on the first edge after rst_ni rises.
- Arithmetic: all adds wrap modulo 2^DATA_WIDTH. Shifts use b[4:0] inside the alu.

Decomposition:
- pkg_config gains ASEL_* (2-bit), BSEL_* (1-bit) and BR_* (4-bit) localparams, or an enum typedef.
- Existing OP_ALU_* and DATA_WIDTH are reused.
- Sub-module: the existing `alu`, instantiated unchanged.
- Branch comparator stays inline; no further sub-modules.

Test Plan:
- ADD: rs1=5, rs2=7, a=RS1, b=RS2, rd=3, ready_i=1 → next cycle valid_o=1, result_o=0000_000C, rd_we_o=1, redirect_o=0.
- BLT taken: rs1=FFFF_FFF0, rs2=0000_0010, pc=0000_0100, imm=0000_0020, a=PC, b=IMM → redirect_o pulses 1 cycle, redirect_pc_o=0000_0120, rd_we_o=0. Same with BLTU → no redirect.
- JALR: rs1=0000_1003, imm=0000_0004, pc=0000_0200, rd=1 → result_o=0000_0204, redirect_pc_o=0000_1006 (bit 0 cleared), redirect 1 cycle.
- Backpressure: ready_i=0 with entry held and valid_i=1 → ready_o=0, outputs stable for 3 cycles. ready_i=1 → consume and accept on the same edge, valid_o stays 1 with new result.
- Flush: valid_i=1 and flush_i=1 with held entry → next cycle valid_o=0, nothing accepted. rd=0 with rd_we_i=1 → rd_we_o=0.
- Async reset: drop rst_ni mid-cycle while valid_o=1 → valid_o=0 immediately, before any clock edge; outputs 0.
